// File: rtl/alu_seq_pkg.sv
// Shared op codes, compare-flag encodings and FSM states for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam logic [1:0] FLG_GT = 2'b00;
    localparam logic [1:0] FLG_EQ = 2'b01;
    localparam logic [1:0] FLG_LT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: shift-add multiply, or restoring divide when ALU_SEQ_DIV_EN is defined.
// Latency: loads on start, then WIDTH steps; res is the final value during the step where last=1.
// Backpressure: none; the caller gates start/step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
`ifdef ALU_SEQ_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res
);

    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc, x, y;
    logic [WIDTH-1:0] acc_nxt, x_nxt, y_nxt;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic             ge;
`endif

    // x is the multiplicand (mul) or divisor (div); y is the multiplier or the dividend/quotient
    always_comb begin
        acc_nxt = acc + (y[0] ? x : '0);
        x_nxt   = x << 1;
        y_nxt   = y >> 1;
        res     = acc_nxt;
`ifdef ALU_SEQ_DIV_EN
        rem_sh  = {acc, y[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, x});
        if (div_mode) begin
            acc_nxt = ge ? (rem_sh[WIDTH-1:0] - x) : rem_sh[WIDTH-1:0];
            x_nxt   = x;
            y_nxt   = {y[WIDTH-2:0], ge};
            res     = y_nxt;
        end
`endif
    end

    assign last = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
            x   <= '0;
            y   <= '0;
        end else if (start) begin
            cnt <= SHW'(WIDTH - 1);
            acc <= '0;
`ifdef ALU_SEQ_DIV_EN
            x   <= div_mode ? b : a;
            y   <= div_mode ? a : b;
`else
            x   <= a;
            y   <= b;
`endif
        end else if (step) begin
            cnt <= cnt - 1'b1;
            acc <= acc_nxt;
            x   <= x_nxt;
            y   <= y_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; optional divider under ALU_SEQ_DIV_EN.
// Latency: 1 edge for logic/arith/shift/CMP, WIDTH edges for MUL (and DIV).
// Backpressure: in_ready drops while iterating or while an unconsumed result is held.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags,
    output logic             busy
);

    state_t           state, state_nxt;
    logic             accept, is_iter, step, last;
    logic [WIDTH-1:0] alu_res, iter_res;

    assign step     = (state != S_IDLE);
    assign busy     = step;
    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef ALU_SEQ_DIV_EN
    logic div_mode;
    assign div_mode = (state == S_DIV) || ((state == S_IDLE) && (op == OP_DIV));
    assign is_iter  = (op == OP_MUL) || (op == OP_DIV);
`else
    assign is_iter  = (op == OP_MUL);
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_CMP:  alu_res = a - b;
            OP_NOT:  alu_res = ~a;
            OP_SLL:  alu_res = a << b[SHW-1:0];
            OP_SRA:  alu_res = $signed(a) >>> b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    alu_seq_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_iter),
        .step     (step),
`ifdef ALU_SEQ_DIV_EN
        .div_mode (div_mode),
`endif
        .a        (a),
        .b        (b),
        .last     (last),
        .res      (iter_res)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (op == OP_MUL))
                    state_nxt = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                else if (accept && (op == OP_DIV))
                    state_nxt = S_DIV;
`endif
            end
            S_MUL, S_DIV: if (last) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Starting an iterative op consumes any held result, so out_valid drops until it finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else if (step && last) begin
            result    <= iter_res;
            out_valid <= 1'b1;
        end else if (accept && !is_iter) begin
            result    <= alu_res;
            out_valid <= 1'b1;
        end else if (accept || out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Signed compare, independent of the wrapped difference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags <= FLG_GT;
        else if (accept && (op == OP_CMP))
            flags <= ($signed(a) == $signed(b)) ? FLG_EQ :
                     ($signed(a) <  $signed(b)) ? FLG_LT : FLG_GT;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Single-cycle logic/arithmetic ops; iterative shift-add multiply.
- Registered compare flags that persist between CMPs; optional iterative divider.
- Sits between the decode/operand-fetch stage and writeback; the datapath stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of 2).
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block accepts a new op this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation code.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result.
- flags  out  2  registered compare flags: 01 equal, 10 A<B signed, 00 A>B.
- busy  out  1  high while in MUL or DIV state.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0; flags=00; out_valid=0; busy=0; the internal count and accumulator clear. Reset mid-multiply abandons the op; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept occurs when in_valid && in_ready at a rising edge.
- Op codes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 ADD, 0100 SUB (mod 2^WIDTH).
  - 0101 CMP: result=a-b; flags set from the signed comparison of a and b, not the wrapped difference's sign.
  - 0110 NOT a.
  - 0111 SLL: a << b[SHW-1:0], zero fill.
  - 1000 MUL: low WIDTH bits of a*b, unsigned/two's-complement identical.
  - 1001 DIV: only with DIV_EN.
  - 1010 SRA: a >>> b[SHW-1:0].
  - Others: result=0.
- flags update only on an accepted CMP. All other ops leave flags unchanged.
- Single-cycle ops: result and out_valid set at the accepting edge (latency 1). State stays IDLE.
- MUL FSM: IDLE -> MUL on accept. The multiplicand, multiplier and accumulator are loaded and cnt=WIDTH-1. Each MUL cycle conditionally adds the multiplicand (LSB of the multiplier), shifts the multiplicand left and the multiplier right, and decrements cnt. On the edge where cnt==0, the result is written, out_valid=1 and the FSM returns to IDLE. Latency is WIDTH edges after accept.
- Output hold: result/out_valid are stable while out_valid && !out_ready.
  - out_ready without a new accept clears out_valid next edge.
  - Consume and accept on the same edge: the new single-cycle result overwrites and out_valid stays 1. For MUL, out_valid drops to 0.
- in_valid while busy is ignored; the producer must hold it.
- out_ready while !out_valid has no effect.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: op 1001 is unsigned restoring division a/b. It adds a DIV state with WIDTH-cycle latency, same FSM shape as MUL.
  - b==0 gives result all-ones, with flags unchanged.
  - The remainder is discarded.
- Undefined: 1001 is treated as an undefined op (result=0, latency 1), and no divider logic is synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - op-code localparams (OP_AND..OP_SRA, OP_DIV);
  - flag encodings (FLG_GT=2'b00, FLG_EQ=2'b01, FLG_LT=2'b10);
  - FSM state encoding (S_IDLE, S_MUL, S_DIV).
- One natural sub-module: alu_seq_iter, the shared shift-add/restoring iteration datapath (counter, accumulator, mode input mul/div). The top module keeps the handshake, single-cycle ops and the flag register.

Test Plan:
- Reset then idle: check result=0, flags=00, out_valid=0, in_ready=1. Assert rst_n=0 mid-MUL: out_valid stays 0 and in_ready returns 1 after release.
- ADD a=0xFFFF_FFFF, b=1: out_valid one cycle after accept, result=0. SLL a=0x0000_00FF, b=40: result=0x0000_FF00.
- CMP a=0x8000_0000, b=1: flags=10, result=0x7FFF_FFFF. CMP 5,5 gives flags=01. A following AND must leave flags=01.
- MUL a=0x0001_0003, b=0x0000_0005:
  - busy for 32 cycles and in_ready=0 throughout;
  - result=0x0005_000F after exactly 32 edges.
  - in_valid held during busy is not accepted twice.
- Back-pressure: issue SUB 10-3 with out_ready=0 for 5 cycles. result=7 holds and in_ready=0. Then pulse out_ready with a new XOR 0xF0^0xFF accepted the same edge: result=0x0F and out_valid stays 1.
- With ALU_SEQ_DIV_EN: 100/7 gives 14 after 32 edges; 5/0 gives 0xFFFF_FFFF. Without the macro, op 1001 gives result=0 in 1 cycle.
